// File: rtl/divisor_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package divisor_pkg;

  typedef enum logic {
    TOGGLE = 1'b0,
    PULSE  = 1'b1
  } mode_t;

  localparam int DEFAULT_DIV = 10000000;

endpackage

// File: rtl/divisor_canal.sv
// One divider channel: counter, active/shadow settings, pending flag and registered outputs.
// Shadow settings move to the active registers only on a wrap or while disabled.
module divisor_canal
  import divisor_pkg::*;
#(
  parameter int WIDTH   = 27,
  parameter int DEF_DIV = DEFAULT_DIV
) (
  input  logic             CLOCKIN,
  input  logic             RESET,
  input  logic             enable,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  input  mode_t            wr_mode,
  output logic             pending,
  output logic             CLOCKOUT,
  output logic             TICK
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] div_sh;
  logic [WIDTH-1:0] last;
  mode_t            mode_act;
  mode_t            mode_sh;
  logic             wrap;

  // Divisors 0 and 1 both give a wrap on every enabled cycle.
  always_comb begin
    last = (div_act > WIDTH'(1)) ? div_act - WIDTH'(1) : '0;
    wrap = enable && (cnt == last);
  end

  always_ff @(posedge CLOCKIN) begin
    if (!RESET) begin
      cnt      <= '0;
      div_act  <= WIDTH'(DEF_DIV);
      div_sh   <= WIDTH'(DEF_DIV);
      mode_act <= TOGGLE;
      mode_sh  <= TOGGLE;
      pending  <= 1'b0;
      CLOCKOUT <= 1'b0;
      TICK     <= 1'b0;
    end else begin
      if (!enable) begin
        cnt      <= '0;
        CLOCKOUT <= 1'b0;
        TICK     <= 1'b0;
      end else if (wrap) begin
        cnt      <= '0;
        TICK     <= 1'b1;
        CLOCKOUT <= (mode_act == TOGGLE) ? ~CLOCKOUT : 1'b0;
      end else begin
        cnt  <= cnt + WIDTH'(1);
        TICK <= 1'b0;
      end

      // A write is only accepted while nothing is pending, so it never collides with an apply.
      if (pending && (!enable || wrap)) begin
        div_act  <= div_sh;
        mode_act <= mode_sh;
        pending  <= 1'b0;
        if (mode_sh == PULSE) begin
          CLOCKOUT <= 1'b0;
        end
      end else if (wr) begin
        div_sh  <= wr_div;
        mode_sh <= wr_mode;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/divisor_multicanal.sv
// NUM_CH independent glitch-free clock dividers sharing one valid/ready configuration port.
module divisor_multicanal #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = divisor_pkg::DEFAULT_DIV,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCKIN,
  input  logic              RESET,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] CLOCKOUT,
  output logic [NUM_CH-1:0] TICK
);

  import divisor_pkg::*;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr_stb;

  // Out-of-range channel numbers always look ready so the write is swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_ch) == i) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_stb[g] = cfg_valid && cfg_ready && (int'(cfg_ch) == g);

    divisor_canal #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEFAULT_DIV)
    ) u_canal (
      .CLOCKIN  (CLOCKIN),
      .RESET    (RESET),
      .enable   (ch_enable[g]),
      .wr       (wr_stb[g]),
      .wr_div   (cfg_div),
      .wr_mode  (mode_t'(cfg_mode)),
      .pending  (pending[g]),
      .CLOCKOUT (CLOCKOUT[g]),
      .TICK     (TICK[g])
    );
  end

endmodule

// File: tb/tb_divisor_multicanal.sv
// Bench for divisor_multicanal: directed scenarios plus random traffic against a countdown reference model.
module tb_divisor_multicanal;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEF    = 4;

  logic              CLOCKIN = 1'b0;
  logic              RESET;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] CLOCKOUT;
  logic [NUM_CH-1:0] TICK;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel counts down the cycles left until its next tick.
  int m_div  [NUM_CH];
  int m_sdiv [NUM_CH];
  int m_left [NUM_CH];
  bit m_mode [NUM_CH];
  bit m_smode[NUM_CH];
  bit m_pend [NUM_CH];
  bit m_clk  [NUM_CH];
  bit m_tick [NUM_CH];
  bit m_took;

  divisor_multicanal #(
    .NUM_CH      (NUM_CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEF)
  ) dut (
    .CLOCKIN   (CLOCKIN),
    .RESET     (RESET),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .ch_enable (ch_enable),
    .CLOCKOUT  (CLOCKOUT),
    .TICK      (TICK)
  );

  always #5 CLOCKIN = ~CLOCKIN;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int eff(int d);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic bit modelReady(int ch);
    return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
  endfunction

  task automatic modelApply(int i);
    m_div[i]  = m_sdiv[i];
    m_mode[i] = m_smode[i];
    m_pend[i] = 1'b0;
    if (m_smode[i]) m_clk[i] = 1'b0;
  endtask

  task automatic modelEdge();
    int c;
    bit take;
    c      = int'(cfg_ch);
    take   = RESET && cfg_valid && modelReady(c);
    m_took = take;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!RESET) begin
        m_div[i]  = DEF;
        m_mode[i] = 1'b0;
        m_pend[i] = 1'b0;
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
        m_left[i] = DEF;
      end else begin
        if (!ch_enable[i]) begin
          m_clk[i]  = 1'b0;
          m_tick[i] = 1'b0;
          if (m_pend[i]) modelApply(i);
          m_left[i] = eff(m_div[i]);
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_tick[i] = 1'b1;
            m_clk[i]  = m_mode[i] ? 1'b0 : ~m_clk[i];
            if (m_pend[i]) modelApply(i);
            m_left[i] = eff(m_div[i]);
          end else begin
            m_tick[i] = 1'b0;
          end
        end
        if (take && c == i) begin
          m_sdiv[i]  = int'(cfg_div);
          m_smode[i] = cfg_mode;
          m_pend[i]  = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      assert (TICK[i] === m_tick[i]) else begin
        errors++;
        $error("[TB] FAIL tick%0d got %b expected %b", i, TICK[i], m_tick[i]);
      end
      checks++;
      assert (CLOCKOUT[i] === m_clk[i]) else begin
        errors++;
        $error("[TB] FAIL clockout%0d got %b expected %b", i, CLOCKOUT[i], m_clk[i]);
      end
    end
    checks++;
    assert (cfg_ready === modelReady(int'(cfg_ch))) else begin
      errors++;
      $error("[TB] FAIL cfg_ready ch%0d got %b expected %b", cfg_ch, cfg_ready, modelReady(int'(cfg_ch)));
    end
  endtask

  // One clock cycle: drive inputs, advance model on the edge, compare on the falling edge.
  task automatic applyStimulus(input bit v, input int ch, input int d, input bit m,
                               input logic [NUM_CH-1:0] en, input bit rst_n);
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = WIDTH'(d);
    cfg_mode  = m;
    ch_enable = en;
    RESET     = rst_n;
    @(posedge CLOCKIN);
    modelEdge();
    @(negedge CLOCKIN);
    checkOutput();
  endtask

  task automatic expectEq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    logic [NUM_CH-1:0] en;
    int q[$];
    int first;
    int k;
    bit done;

    en = '0;
    applyStimulus(0, 0, 0, 0, en, 0);
    applyStimulus(0, 0, 0, 0, en, 0);

    // Channel 0 at the default divisor of 4.
    en = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(0, 0, 0, 0, en, 1);
      if (TICK[0]) q.push_back(c);
    end
    expectEq("tick0_count", q.size(), 3);
    if (q.size() == 3) begin
      expectEq("tick0_first", q[0], 4);
      expectEq("tick0_second", q[1], 8);
      expectEq("tick0_third", q[2], 12);
    end

    // Channel 1 at div 5, then reprogrammed to div 3 PULSE mid-period.
    applyStimulus(1, 1, 5, 0, en, 1);
    en = 4'b0011;
    for (int c = 0; c < 7; c++) applyStimulus(0, 0, 0, 0, en, 1);
    applyStimulus(1, 1, 3, 1, en, 1);
    for (int c = 0; c < 14; c++) applyStimulus(0, 1, 0, 0, en, 1);

    // Channel 2: back-to-back writes, the second must stall.
    en = 4'b0111;
    applyStimulus(0, 2, 0, 0, en, 1);
    applyStimulus(1, 2, 6, 0, en, 1);
    expectEq("ch2_stall_ready", int'(cfg_ready), 0);
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      applyStimulus(1, 2, 2, 0, en, 1);
      done = m_took;
    end
    expectEq("ch2_second_write_taken", int'(done), 1);
    q.delete();
    for (int c = 1; c <= 30; c++) begin
      applyStimulus(0, 2, 0, 0, en, 1);
      if (TICK[2]) q.push_back(c);
    end
    if (q.size() >= 2) expectEq("ch2_final_spacing", q[q.size()-1] - q[q.size()-2], 2);
    else expectEq("ch2_tick_count", q.size(), 2);

    // Channel 3: divisor 0 behaves as 1.
    en = 4'b1111;
    applyStimulus(1, 3, 0, 0, en, 1);
    for (int c = 0; c < 8; c++) applyStimulus(0, 3, 0, 0, en, 1);
    expectEq("ch3_tick_high", int'(TICK[3]), 1);

    // Disable channel 0 mid-period, then re-enable and time the first tick.
    applyStimulus(0, 0, 0, 0, en, 1);
    en[0] = 1'b0;
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, en, 1);
    expectEq("ch0_disabled_clk", int'(CLOCKOUT[0]), 0);
    en[0] = 1'b1;
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      applyStimulus(0, 0, 0, 0, en, 1);
      if (TICK[0]) first = c;
    end
    expectEq("ch0_reenable_latency", first, 4);

    // Reset mid-period with a pending configuration on channel 1.
    applyStimulus(1, 1, 7, 0, en, 1);
    applyStimulus(0, 1, 0, 0, en, 0);
    expectEq("rst_tick", int'(TICK), 0);
    expectEq("rst_clockout", int'(CLOCKOUT), 0);
    expectEq("rst_ready", int'(cfg_ready), 1);
    for (int c = 0; c < 10; c++) applyStimulus(0, 1, 0, 0, en, 1);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, NUM_CH - 1);
        en[k] = ~en[k];
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 9),
                    1'($urandom_range(0, 1)), en, $urandom_range(0, 99) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divisor_multicanal.md
# divisor_multicanal

Parametrised, multi-channel successor to the single fixed-rate frequency divider. It generates NUM_CH independent divided clocks from CLOCKIN. Each channel has a runtime-programmable divisor, a selectable output mode (50 % toggle clock or single-cycle tick) and its own enable. New settings are loaded through a valid/ready configuration port and take effect only on a period boundary, so the outputs never glitch. It sits between the board clock and the timing-driven blocks (display scan, sensor sampling, state-machine pacing).

## Interface
- NUM_CH, 4: number of independent channels (1..16).
- WIDTH, 27: divisor and counter width in bits.
- DEFAULT_DIV, 10000000: divisor loaded into every channel at reset (5 Hz toggle output from a 100 MHz CLOCKIN).
- CLOCKIN  input  1  single system clock; all logic on the rising edge.
- RESET  input  1  synchronous reset, active-low.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  configuration can be accepted for the channel on cfg_ch.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel. Values ≥ NUM_CH are accepted and ignored.
- cfg_div  input  WIDTH  new divisor. 0 is treated as 1.
- cfg_mode  input  1  0 = TOGGLE, 1 = PULSE.
- ch_enable  input  NUM_CH  per-channel run enable.
- CLOCKOUT  output  NUM_CH  divided clock; toggles at each wrap in TOGGLE mode, held 0 in PULSE mode.
- TICK  output  NUM_CH  one-cycle pulse at each wrap, in both modes.

## Operation
- Each channel holds: counter[WIDTH], active divisor, active mode, shadow divisor, shadow mode, and a pending flag.
- Wrap condition: channel enabled and counter == max(div,1) − 1.
  - At wrap: counter ← 0, TICK ← 1, CLOCKOUT toggles if mode is TOGGLE.
  - Otherwise: counter increments and TICK ← 0.
- Configuration handshake:
  - cfg_ready = ~pending[cfg_ch]. It is combinational and does not depend on cfg_valid.
  - Transfer occurs when cfg_valid & cfg_ready. The shadow registers are written and pending is set.
- Pending settings are applied to the active registers:
  - at the next wrap edge, if the channel is enabled; or
  - at the next edge, if the channel is disabled.
  - Applying clears pending.
- Switching the mode to PULSE clears CLOCKOUT at the apply edge. Switching to TOGGLE starts CLOCKOUT from 0.
- ch_enable low: counter held at 0, CLOCKOUT ← 0, TICK ← 0. When re-enabled, the channel starts a full period from 0.
- Divisor 0 or 1 means a wrap every enabled cycle:
  - TICK stays high continuously.
  - CLOCKOUT runs at CLOCKIN/2 in TOGGLE mode.

## Timing
- RESET low at an edge sets every channel to:
  - counter 0, divisor DEFAULT_DIV, mode TOGGLE, pending 0;
  - CLOCKOUT 0, TICK 0; cfg_ready 1.
- Reset mid-period discards the partial count and any pending configuration.
- Enabled channel with divisor D:
  - first TICK is high in the cycle after the D-th edge counted from the first edge where enable is sampled high;
  - thereafter, TICK repeats every D cycles;
  - in TOGGLE mode, CLOCKOUT has period 2·D and a 50 % duty cycle.
- Configuration accepted on the same edge as that channel's wrap: the wrap uses the old settings, and the new ones apply at the following wrap.
- Configuration latency is at most one current period for an enabled channel, and exactly 1 cycle for a disabled channel.
- A second write to a channel is back-pressured (cfg_ready low) until that channel's pending settings have been applied. Other channels are unaffected.
- Outputs are registered; there is no combinational path from inputs to CLOCKOUT or TICK.

## Structure
- Package divisor_pkg: mode enum (TOGGLE=0, PULSE=1) and default DEFAULT_DIV constant.
- Sub-module divisor_canal: one channel, containing the counter, active and shadow registers, pending flag and both outputs.
- Top level: instantiates NUM_CH copies of divisor_canal, decodes cfg_ch into per-channel write strobes, and muxes the pending flags to form cfg_ready.

## Test plan
- Reset then enable ch0 with DEFAULT_DIV overridden to 4 -> TICK0 high at cycles 4, 8, 12; CLOCKOUT0 period 8, high for 4 cycles.
- Write ch1 div=3 mode=PULSE while ch1 runs at div=5 -> takes effect after the current 5-cycle period; CLOCKOUT1 cleared at that edge; TICK1 then every 3 cycles.
- Write ch2 twice back-to-back -> second write stalled (cfg_ready low) until the first is applied; final div equals the second value.
- Write div=0 TOGGLE on ch3 -> TICK3 high every enabled cycle; CLOCKOUT3 toggles every cycle.
- Deassert ch_enable mid-period, hold 3 cycles, reassert -> outputs 0 while disabled; next TICK exactly D cycles after re-enable.
- Assert RESET low mid-period with a pending configuration -> all outputs 0 and cfg_ready 1 next cycle; pending configuration discarded; divisor back to DEFAULT_DIV.
